i2c_byte_ctrl: RTL and testbench
================================

Name: i2c_byte_ctrl

Overview:
- Byte-level I2C master sequencer. Drives the 8-bit SDA shift register through its load (en_w), shift (shift_en) and direction (rw_en) controls.
- Generates SCL and open-drain SDA levels, optional START/repeated START and STOP, and the 9th (ACK) bit.
- Sits between the host command interface and the shift register / pad logic.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period; legal values are 2 and above; quarter counter width is clog2(CLK_DIV)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  controller can accept a command (IDLE)
cmd_start  in  1  issue START/repeated START before the byte
cmd_stop  in  1  issue STOP after the ACK bit
cmd_read  in  1  1 = read byte, 0 = write byte
cmd_ack  in  1  read only: bit driven in ACK slot (0 = ACK, 1 = NACK)
sr_sda_out  in  1  current TX bit from shift register
sda_in  in  1  synchronised SDA line level
sr_en_w  out  1  one-cycle pulse: load shift register TX byte
sr_shift_en  out  1  one-cycle pulse: shift shift register
sr_rw_en  out  1  direction to shift register (1 = read)
scl_o  out  1  SCL level (0 = drive low, 1 = release)
sda_o  out  1  SDA level (0 = drive low, 1 = release)
busy  out  1  transfer in progress (not IDLE)
done  out  1  one-cycle pulse: command complete
ack_out  out  1  write: sampled slave ACK (1 = NACK); read: 0

Behaviour:
- Reset values:
  - state = IDLE, qcnt = 0, bit_cnt = 0, bus_held = 0.
  - scl_o = 1, sda_o = 1, cmd_ready = 1, busy = 0.
  - sr_en_w = 0, sr_shift_en = 0, sr_rw_en = 0, done = 0, ack_out = 0.
- Reset mid-transfer returns to the reset values on the next edge. No STOP is generated.
- Timing base: qcnt counts 0..CLK_DIV-1. tick = (qcnt == CLK_DIV-1). Each phase q0..q3 lasts CLK_DIV cycles. qcnt is cleared on command accept.
- Accept: cmd_valid && cmd_ready.
  - Latch start/stop/read/ack fields.
  - sr_rw_en <= cmd_read; it holds until the next accept.
  - If cmd_read = 0, pulse sr_en_w in the accept cycle + 1, before the first shift.
  - Next state is START if (cmd_start || !bus_held), else BIT. A START is forced when the bus is free.
- States and levels (q0/q1/q2/q3):
  - IDLE: cmd_ready = 1, sda_o = 1. scl_o = 0 if bus_held, else 1.
  - START: SCL = hold/1/1/0, SDA = 1/1/0/0. After q3, go to BIT with bit_cnt = 0 and bus_held = 1.
  - BIT: SCL = 0/1/1/0.
    - Write: SDA = sr_sda_out in all four phases.
    - Read: SDA = 1 in all four phases.
    - Read: sr_shift_en pulses on the cycle after the q2 tick (sample while SCL high).
    - Write: sr_shift_en pulses on the cycle after the q3 tick.
    - After q3: bit_cnt++. When bit_cnt reaches 7, go to ACK.
  - ACK: SCL = 0/1/1/0.
    - Write: SDA = 1; ack_out <= sda_in at the q2 tick.
    - Read: SDA = latched cmd_ack; ack_out <= 0.
    - After q3: go to STOP if the stop flag is set, else IDLE (bus_held stays 1).
  - STOP: SCL = 0/1/1/1, SDA = 0/0/1/1. After q3, go to IDLE with bus_held = 0.
- Shift pulse count: exactly 8 sr_shift_en pulses per byte. No shift in the ACK slot.
- done and cmd_ready:
  - done pulses, and cmd_ready rises, in the cycle after the last quarter tick.
  - Latency: accept at cycle 0, N quarters total, done at cycle N*CLK_DIV + 1.
  - N = 36 + 4*start + 4*stop.
- SDA transitions occur only in q0 or q3 of BIT/ACK (SCL low). START and STOP change SDA only while SCL is high.
- Simultaneous start+stop in one command is legal.
- cmd_valid while busy is ignored (cmd_ready = 0). No queuing.

Test Plan:
- CLK_DIV=4, write 0xA5, start=1, stop=1, slave drives ACK=0:
  - SDA bits seen at SCL rising edges are 1,0,1,0,0,1,0,1.
  - 8 shift pulses, 1 en_w pulse; done at cycle 177; ack_out = 0; scl_o = sda_o = 1 after.
- Write 0x3C, no stop, slave NACK (sda_in = 1 in ACK slot):
  - ack_out = 1; done at cycle 145; IDLE with scl_o = 0 (bus_held).
- Read after held bus, start=0, stop=1, cmd_ack=1, slave drives 0x5A:
  - No START; 8 shift pulses at q2 end with sr_rw_en = 1; shift register holds 0x5A at done.
  - ACK slot SDA = 1; STOP emitted; done at cycle 161.
- Repeated START: write 0x90 without stop, then cmd_start=1 read:
  - Second transfer shows SDA falling while SCL is high after SCL re-rises; no STOP between the bytes.
- Reset during BIT phase 3 of bit 4 → next cycle:
  - scl_o = 1, sda_o = 1, cmd_ready = 1, busy = 0, bus_held = 0.
  - A following write with start=0 still emits a START.
- cmd_valid held high during a transfer:
  - Exactly one accept per done.
  - Back-to-back commands accepted in the done cycle; the next transfer starts without a gap cycle.

Source files
------------

// File: rtl/i2c_byte_ctrl_if.sv
// Purpose : host command, shift-register and pad signals of the I2C byte sequencer.
// Ports   : master = sequencer side, slave = host / shift register / pad side.
// Notes   : pure signal bundle, no logic.
interface i2c_byte_ctrl_if;
   logic cmd_valid;
   logic cmd_ready;
   logic cmd_start;
   logic cmd_stop;
   logic cmd_read;
   logic cmd_ack;
   logic sr_sda_out;
   logic sda_in;
   logic sr_en_w;
   logic sr_shift_en;
   logic sr_rw_en;
   logic scl_o;
   logic sda_o;
   logic busy;
   logic done;
   logic ack_out;

   modport master (
      input  cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_ack, sr_sda_out, sda_in,
      output cmd_ready, sr_en_w, sr_shift_en, sr_rw_en, scl_o, sda_o, busy, done, ack_out
   );

   modport slave (
      output cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_ack, sr_sda_out, sda_in,
      input  cmd_ready, sr_en_w, sr_shift_en, sr_rw_en, scl_o, sda_o, busy, done, ack_out
   );
endinterface

// File: rtl/i2c_byte_ctrl.sv
// Purpose : byte-level I2C master sequencer (optional START, 8 data bits, ACK slot, optional STOP).
// Latency : accept at cycle 0, done at cycle (36 + 4*start + 4*stop)*CLK_DIV + 1.
// Backpr. : one command at a time; cmd_ready only in IDLE, cmd_valid ignored while busy.
// Ports   : clk, rst (sync, active-high); bus = i2c_byte_ctrl_if.master carrying the command
//           handshake, shift-register controls (en_w/shift_en/rw_en, sr_sda_out) and pad levels.
module i2c_byte_ctrl #(
   parameter int unsigned CLK_DIV = 4
) (
   input logic           clk,
   input logic           rst,
   i2c_byte_ctrl_if.master bus
);
   localparam int unsigned   QW   = $clog2(CLK_DIV);
   localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_BIT, ST_ACK, ST_STOP} state_t;

   state_t        state_q, state_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    ph_q, ph_d;        // current quarter q0..q3
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          held_q, held_d;    // SCL left low after a byte without STOP
   logic          stop_q, stop_d;
   logic          read_q, read_d;
   logic          ack_q, ack_d;
   logic          rw_q, rw_d;
   logic          scl_q, scl_d;
   logic          sda_lvl_q, sda_lvl_d;
   logic          sda_sel_q, sda_sel_d; // 1: SDA follows the shift register output directly
   logic          en_w_q, en_w_d;
   logic          shift_q, shift_d;
   logic          done_q, done_d;
   logic          ack_out_q, ack_out_d;
   logic          tick, last;

   assign tick = (qcnt_q == QMAX);
   assign last = tick && (ph_q == 2'd3);

   always_comb begin
      state_d   = state_q;
      qcnt_d    = tick ? '0 : qcnt_q + QW'(1);
      ph_d      = ph_q + {1'b0, tick};
      bit_cnt_d = bit_cnt_q;
      held_d    = held_q;
      stop_d    = stop_q;
      read_d    = read_q;
      ack_d     = ack_q;
      rw_d      = rw_q;
      ack_out_d = ack_out_q;
      en_w_d    = 1'b0;
      shift_d   = 1'b0;
      done_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            qcnt_d = '0;
            ph_d   = '0;
            if (bus.cmd_valid) begin
               stop_d    = bus.cmd_stop;
               read_d    = bus.cmd_read;
               ack_d     = bus.cmd_ack;
               rw_d      = bus.cmd_read;
               en_w_d    = !bus.cmd_read;
               bit_cnt_d = '0;
               // A free bus always needs a START before any data bit.
               state_d   = (bus.cmd_start || !held_q) ? ST_START : ST_BIT;
            end
         end
         ST_START: begin
            if (last) begin
               state_d   = ST_BIT;
               bit_cnt_d = '0;
               held_d    = 1'b1;
            end
         end
         ST_BIT: begin
            // Read samples once SCL has been high for a full quarter.
            if (read_q && tick && (ph_q == 2'd2)) shift_d = 1'b1;
            if (last) begin
               if (!read_q) shift_d = 1'b1;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (tick && (ph_q == 2'd2)) ack_out_d = read_q ? 1'b0 : bus.sda_in;
            if (last) begin
               state_d = stop_q ? ST_STOP : ST_IDLE;
               done_d  = !stop_q;
            end
         end
         ST_STOP: begin
            if (last) begin
               state_d = ST_IDLE;
               held_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pad levels are computed for the state/quarter being entered so they line up with it.
      scl_d     = 1'b1;
      sda_lvl_d = 1'b1;
      sda_sel_d = 1'b0;
      unique case (state_d)
         ST_IDLE:  scl_d = !held_d;
         ST_START: begin
            scl_d     = (ph_d == 2'd0) ? !held_q : (ph_d != 2'd3);
            sda_lvl_d = !ph_d[1];
         end
         ST_BIT: begin
            scl_d     = ph_d[0] ^ ph_d[1];
            sda_sel_d = !read_d;
         end
         ST_ACK: begin
            scl_d     = ph_d[0] ^ ph_d[1];
            sda_lvl_d = read_d ? ack_d : 1'b1;
         end
         ST_STOP: begin
            scl_d     = (ph_d != 2'd0);
            sda_lvl_d = ph_d[1];
         end
         default: scl_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         qcnt_q    <= '0;
         ph_q      <= '0;
         bit_cnt_q <= '0;
         held_q    <= 1'b0;
         stop_q    <= 1'b0;
         read_q    <= 1'b0;
         ack_q     <= 1'b0;
         rw_q      <= 1'b0;
         scl_q     <= 1'b1;
         sda_lvl_q <= 1'b1;
         sda_sel_q <= 1'b0;
         en_w_q    <= 1'b0;
         shift_q   <= 1'b0;
         done_q    <= 1'b0;
         ack_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         ph_q      <= ph_d;
         bit_cnt_q <= bit_cnt_d;
         held_q    <= held_d;
         stop_q    <= stop_d;
         read_q    <= read_d;
         ack_q     <= ack_d;
         rw_q      <= rw_d;
         scl_q     <= scl_d;
         sda_lvl_q <= sda_lvl_d;
         sda_sel_q <= sda_sel_d;
         en_w_q    <= en_w_d;
         shift_q   <= shift_d;
         done_q    <= done_d;
         ack_out_q <= ack_out_d;
      end
   end

   assign bus.cmd_ready   = (state_q == ST_IDLE);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.scl_o       = scl_q;
   // Data bits pass straight through so a shifted bit reaches the pad within the SCL-low quarter.
   assign bus.sda_o       = sda_sel_q ? bus.sr_sda_out : sda_lvl_q;
   assign bus.sr_en_w     = en_w_q;
   assign bus.sr_shift_en = shift_q;
   assign bus.sr_rw_en    = rw_q;
   assign bus.done        = done_q;
   assign bus.ack_out     = ack_out_q;
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Purpose : directed checks of i2c_byte_ctrl with a shift-register model and an I2C slave model.
// Latency : n/a (testbench).
// Backpr. : n/a (testbench).
module tb_i2c_byte_ctrl;
   localparam int CLK_DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   i2c_byte_ctrl_if bif ();
   i2c_byte_ctrl #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .rst(rst), .bus(bif));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // shift register and slave models
   logic [7:0] tx_byte   = 8'h00;
   logic [7:0] tb_sr     = 8'h00;
   logic       slv_read  = 1'b0;
   logic       slv_start = 1'b0;
   logic       slv_ack   = 1'b1;
   logic [7:0] slv_byte  = 8'h00;
   logic [3:0] sl_n      = 4'd0;
   logic       sl_fell   = 1'b0;
   logic       sl_ackd   = 1'b0;
   logic       scl_d1    = 1'b1;
   logic       slv_drv;
   logic       sda_line;
   int         n_shift   = 0;
   int         n_enw     = 0;

   // line monitor
   int   cyc = 0, acc_cyc = 0, done_cyc = 0;
   int   tot_acc = 0, tot_done = 0, n_b2b = 0;
   int   acc_t [0:63];
   logic rise_bits [0:31];
   int   rise_n = 0, n_start = 0, n_stop = 0;
   logic p_scl = 1'b1, p_sda = 1'b1;

   assign bif.sr_sda_out = tb_sr[7];
   assign sda_line       = bif.sda_o & slv_drv;
   assign bif.sda_in     = sda_line;

   always_comb begin
      slv_drv = 1'b1;
      if (slv_read) begin
         if (sl_n < 4'd8 && (!slv_start || sl_fell)) slv_drv = slv_byte[3'(4'd7 - sl_n)];
      end else if (sl_n == 4'd8 && !sl_ackd) begin
         slv_drv = slv_ack;
      end
   end

   always @(posedge clk) begin
      scl_d1 <= bif.scl_o;
      if (bif.cmd_valid && bif.cmd_ready) begin
         sl_n    <= 4'd0;
         sl_fell <= 1'b0;
         sl_ackd <= 1'b0;
         n_shift <= 0;
         n_enw   <= 0;
      end else begin
         if (bif.sr_shift_en) begin
            sl_n    <= sl_n + 4'd1;
            n_shift <= n_shift + 1;
         end
         if (bif.sr_en_w) n_enw <= n_enw + 1;
         if (scl_d1 && !bif.scl_o) begin
            sl_fell <= 1'b1;
            if (sl_n == 4'd8) sl_ackd <= 1'b1;
         end
      end
      if (bif.sr_en_w)          tb_sr <= tx_byte;
      else if (bif.sr_shift_en) tb_sr <= bif.sr_rw_en ? {tb_sr[6:0], bif.sda_in} : {tb_sr[6:0], 1'b0};
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bif.cmd_valid && bif.cmd_ready) begin
         acc_cyc         <= cyc;
         acc_t[tot_acc]  <= cyc;
         tot_acc         <= tot_acc + 1;
         rise_n          <= 0;
         n_start         <= 0;
         n_stop          <= 0;
         if (bif.done) n_b2b <= n_b2b + 1;
      end else begin
         if (!p_scl && bif.scl_o && rise_n < 32) begin
            rise_bits[rise_n] <= sda_line;
            rise_n            <= rise_n + 1;
         end
         if (p_scl && bif.scl_o && p_sda && !sda_line) n_start <= n_start + 1;
         if (p_scl && bif.scl_o && !p_sda && sda_line) n_stop <= n_stop + 1;
      end
      if (bif.done) begin
         done_cyc <= cyc;
         tot_done <= tot_done + 1;
      end
      p_scl <= bif.scl_o;
      p_sda <= sda_line;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rise_byte(input int off);
      logic [7:0] b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], rise_bits[off + i]};
      return b;
   endfunction

   task automatic wait_done(input string tag);
      logic got = 1'b0;
      int   k   = 0;
      while (k < 1000 && !got) begin
         @(negedge clk);
         if (bif.done) got = 1'b1;
         k++;
      end
      chk({tag, " done_seen"}, {31'd0, got}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic st, input logic sp, input logic rd, input logic ak,
                        input logic [7:0] tx, input logic sack, input logic [7:0] sbyte);
      @(posedge clk);
      #1;
      bif.cmd_start = st;
      bif.cmd_stop  = sp;
      bif.cmd_read  = rd;
      bif.cmd_ack   = ak;
      bif.cmd_valid = 1'b1;
      tx_byte       = tx;
      slv_read      = rd;
      slv_start     = st;
      slv_ack       = sack;
      slv_byte      = sbyte;
   endtask

   task automatic run_cmd(input string tag, input logic st, input logic sp, input logic rd, input logic ak,
                          input logic [7:0] tx, input logic sack, input logic [7:0] sbyte);
      issue(st, sp, rd, ak, tx, sack, sbyte);
      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b0;
      wait_done(tag);
   endtask

   task automatic check_cmd(input string tag, input int lat, input int rises, input int starts,
                            input int stops, input int enws);
      chk({tag, " latency"}, done_cyc - acc_cyc, lat);
      chk({tag, " scl_rises"}, rise_n, rises);
      chk({tag, " starts"}, n_start, starts);
      chk({tag, " stops"}, n_stop, stops);
      chk({tag, " shifts"}, n_shift, 8);
      chk({tag, " en_w"}, n_enw, enws);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap_a, snap_b, k, nd;
      bif.cmd_valid = 1'b0;
      bif.cmd_start = 1'b0;
      bif.cmd_stop  = 1'b0;
      bif.cmd_read  = 1'b0;
      bif.cmd_ack   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      chk("rst cmd_ready", bif.cmd_ready, 1);
      chk("rst busy", bif.busy, 0);
      chk("rst scl_o", bif.scl_o, 1);
      chk("rst sda_o", bif.sda_o, 1);
      chk("rst en_w", bif.sr_en_w, 0);
      chk("rst shift_en", bif.sr_shift_en, 0);
      chk("rst rw_en", bif.sr_rw_en, 0);
      chk("rst done", bif.done, 0);
      chk("rst ack_out", bif.ack_out, 0);

      // write 0xA5 with START and STOP, slave ACKs
      run_cmd("wrA5", 1, 1, 0, 0, 8'hA5, 1'b0, 8'h00);
      check_cmd("wrA5", 177, 10, 1, 1, 1);
      chk("wrA5 data", rise_byte(0), 8'hA5);
      chk("wrA5 ack_line", rise_bits[8], 0);
      chk("wrA5 ack_out", bif.ack_out, 0);
      chk("wrA5 scl_idle", bif.scl_o, 1);
      chk("wrA5 sda_idle", bif.sda_o, 1);

      // write 0x90 with START, no STOP: bus stays held
      run_cmd("wr90", 1, 0, 0, 0, 8'h90, 1'b0, 8'h00);
      check_cmd("wr90", 161, 9, 1, 0, 1);
      chk("wr90 data", rise_byte(0), 8'h90);
      chk("wr90 scl_held", bif.scl_o, 0);

      // write 0x3C on held bus, no START/STOP, slave NACKs
      run_cmd("wr3C", 0, 0, 0, 0, 8'h3C, 1'b1, 8'h00);
      check_cmd("wr3C", 145, 9, 0, 0, 1);
      chk("wr3C data", rise_byte(0), 8'h3C);
      chk("wr3C ack_out", bif.ack_out, 1);
      chk("wr3C scl_held", bif.scl_o, 0);
      chk("wr3C cmd_ready", bif.cmd_ready, 1);

      // read 0x5A on held bus, NACK from master, STOP
      run_cmd("rd5A", 0, 1, 1, 1, 8'h00, 1'b1, 8'h5A);
      check_cmd("rd5A", 161, 10, 0, 1, 0);
      chk("rd5A sr", tb_sr, 8'h5A);
      chk("rd5A ack_line", rise_bits[8], 1);
      chk("rd5A ack_out", bif.ack_out, 0);
      chk("rd5A rw_en", bif.sr_rw_en, 1);
      chk("rd5A scl_idle", bif.scl_o, 1);

      // repeated START: write without STOP then START+read
      run_cmd("rs_wr", 1, 0, 0, 0, 8'h90, 1'b0, 8'h00);
      chk("rs_wr stops", n_stop, 0);
      chk("rs_wr latency", done_cyc - acc_cyc, 161);
      run_cmd("rs_rd", 1, 1, 1, 0, 8'h00, 1'b1, 8'hC3);
      check_cmd("rs_rd", 177, 11, 1, 1, 0);
      chk("rs_rd sr", tb_sr, 8'hC3);
      chk("rs_rd ack_line", rise_bits[9], 0);

      // reset in the SCL-low quarter of bit 4
      issue(0, 0, 0, 0, 8'h66, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b0;
      k = 0;
      while (k < 1000 && n_shift < 4) begin @(negedge clk); k++; end
      while (k < 1000 && !bif.scl_o) begin @(negedge clk); k++; end
      while (k < 1000 && bif.scl_o) begin @(negedge clk); k++; end
      chk("mid_rst reached_bit4_q3", {31'd0, (k < 1000)}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst scl_o", bif.scl_o, 1);
      chk("mid_rst sda_o", bif.sda_o, 1);
      chk("mid_rst cmd_ready", bif.cmd_ready, 1);
      chk("mid_rst busy", bif.busy, 0);
      chk("mid_rst shift_en", bif.sr_shift_en, 0);

      run_cmd("post_rst", 0, 1, 0, 0, 8'h66, 1'b0, 8'h00);
      check_cmd("post_rst", 177, 10, 1, 1, 1);
      chk("post_rst data", rise_byte(0), 8'h66);

      // cmd_valid held high across transfers
      snap_a = tot_acc;
      snap_b = n_b2b;
      nd     = tot_done;
      issue(0, 0, 0, 0, 8'h81, 1'b0, 8'h00);
      k = 0;
      while (k < 2000 && (tot_done - nd) < 2) begin @(negedge clk); k++; end
      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b0;
      wait_done("b2b");
      chk("b2b accepts", tot_acc - snap_a, 3);
      chk("b2b dones", tot_done - nd, 3);
      chk("b2b accept_in_done", n_b2b - snap_b, 2);
      chk("b2b gap1", acc_t[snap_a + 1] - acc_t[snap_a], 161);
      chk("b2b gap2", acc_t[snap_a + 2] - acc_t[snap_a + 1], 145);
      chk("b2b data", rise_byte(0), 8'h81);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
